// File: rtl/disp_mux_pwm.sv
// disp_mux_pwm: time-multiplexed common-anode seven-segment driver with brightness PWM,
//   per-digit enable/blink, inter-digit dead time and frame-synchronous input shadowing.
// Latency: 1 cycle from counter/shadow state to the registered an/sseg outputs.
// Backpressure: none; free-running scan, inputs are sampled once per frame.
// Optional feature macro: DISP_MUX_PWM_LAMP_TEST_EN adds a lamp_test input (all segments on).

`default_nettype none

module disp_mux_pwm #(
  parameter int N_DIGITS     = 8,
  parameter int SUB_CYC      = 1024,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*N_DIGITS-1:0] segs_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic [3:0]            brightness,
`ifdef DISP_MUX_PWM_LAMP_TEST_EN
  input  logic                  lamp_test,
`endif
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_start
);

  // Counter widths; SUB_CYC = 1 still gets a 1-bit counter that simply stays at 0.
  localparam int CYC_W = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
  localparam int DIG_W = $clog2(N_DIGITS);
  localparam int FRM_W = $clog2(2 * BLINK_FRAMES);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SUB_CYC - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(2 * BLINK_FRAMES - 1);
  localparam logic [FRM_W-1:0] FRM_HALF = FRM_W'(BLINK_FRAMES);

  // Scan position: cycle within subslot, subslot within digit slot, digit within frame.
  logic [CYC_W-1:0] cyc;
  logic [3:0]       sub;
  logic [DIG_W-1:0] dig;
  // Blink frame counter: first half of its range is the "on" phase.
  logic [FRM_W-1:0] frm;

  // Frame shadow registers; only these feed the display path.
  logic [N_DIGITS-1:0][7:0] seg_sh;
  logic [N_DIGITS-1:0]      en_sh;
  logic [N_DIGITS-1:0]      blink_sh;
  logic [3:0]               br_sh;
  logic                     phase_sh;
`ifdef DISP_MUX_PWM_LAMP_TEST_EN
  logic                     lt_sh;
`endif

  // Combinational helpers.
  logic                frame_load;
  logic                lit;
  logic [7:0]          seg_sel;
  logic [N_DIGITS-1:0] dig_onehot;

  // Frame boundary is the single scan state (0,0,0); the edge leaving it reloads the shadows.
  assign frame_load = (dig == '0) && (sub == 4'd0) && (cyc == '0);
  assign dig_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << dig;

  // Scan counters: cyc -> sub -> dig cascade, each wrapping into the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc <= '0;
      sub <= 4'd0;
      dig <= '0;
    end else if (cyc == CYC_LAST) begin
      cyc <= '0;
      if (sub == 4'd15) begin
        sub <= 4'd0;
        dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end else begin
        sub <= sub + 4'd1;
      end
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

  // Frame load: capture all display inputs at once so no digit shows a half-updated frame;
  // the blink phase is taken from the frame counter before it advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_sh   <= '1;
      en_sh    <= '0;
      blink_sh <= '0;
      br_sh    <= 4'd0;
      phase_sh <= 1'b0;
      frm      <= '0;
    end else if (frame_load) begin
      seg_sh   <= segs_in;
      en_sh    <= digit_en;
      blink_sh <= blink_en;
      br_sh    <= brightness;
      phase_sh <= (frm >= FRM_HALF);
      frm      <= (frm == FRM_LAST) ? '0 : frm + 1'b1;
    end
  end

`ifdef DISP_MUX_PWM_LAMP_TEST_EN
  // Lamp test request is also frame-synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      lt_sh <= 1'b0;
    end else if (frame_load) begin
      lt_sh <= lamp_test;
    end
  end
`endif

  // Lit decision: subslot 0 is dead time; subslots 1..br_sh are on; blink blanks in phase 1.
  always_comb begin
    lit     = (sub != 4'd0) && (sub <= br_sh) && en_sh[dig] && !(blink_sh[dig] && phase_sh);
    seg_sel = seg_sh[dig];
`ifdef DISP_MUX_PWM_LAMP_TEST_EN
    if (lt_sh) begin
      lit     = (sub != 4'd0);
      seg_sel = 8'h00;
    end
`endif
  end

  // Registered pin drivers; at most one anode low because dig_onehot has a single bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= '1;
      sseg        <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? ~dig_onehot : '1;
      sseg        <= lit ? seg_sel : 8'hFF;
      frame_start <= frame_load;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_mux_pwm.sv
// Bench for disp_mux_pwm with N_DIGITS=4, SUB_CYC=2, BLINK_FRAMES=2 (slot 32, frame 128 cycles).
// Expected outputs per edge come from a position-based model and are queued, then popped at #1.
// Directed counts of lit cycles and frame_start pulses confirm brightness, blink and shadowing.

`default_nettype none

module tb_disp_mux_pwm;

  localparam int ND    = 4;
  localparam int SC    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = 16 * SC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] segs_in;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;
`ifdef DISP_MUX_PWM_LAMP_TEST_EN
  logic        lamp_test = 1'b0;
`endif

  always #5 clk = ~clk;

  disp_mux_pwm #(
    .N_DIGITS    (ND),
    .SUB_CYC     (SC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .segs_in    (segs_in),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .brightness (brightness),
`ifdef DISP_MUX_PWM_LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .an         (an),
    .sseg       (sseg),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Model state: edges since reset release and the frame shadows the DUT should hold.
  int          e_cnt = 0;
  logic [31:0] m_seg = '1;
  logic [3:0]  m_en = '0;
  logic [3:0]  m_blink = '0;
  logic [3:0]  m_br = '0;
  logic        m_phase = 1'b0;

  // Observed-output statistics for directed checks.
  int         d0_lit = 0;
  int         d1_lit = 0;
  int         any_lit = 0;
  int         fs_cnt = 0;
  logic [7:0] last_d0 = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, got, exp, e_cnt);
    end
  endtask

  task automatic clr();
    d0_lit  = 0;
    d1_lit  = 0;
    any_lit = 0;
    fs_cnt  = 0;
  endtask

  // One clock: model the edge from scan position and current inputs, queue it, compare at #1.
  task automatic tick();
    exp_t       x;
    exp_t       y;
    int         q;
    int         d;
    int         s;
    logic       lit;
    logic [3:0] oh;
    @(posedge clk);
    if (reset) begin
      x.an    = 4'hF;
      x.sseg  = 8'hFF;
      x.fs    = 1'b0;
      e_cnt   = 0;
      m_seg   = '1;
      m_en    = '0;
      m_blink = '0;
      m_br    = '0;
      m_phase = 1'b0;
    end else begin
      q   = e_cnt % FRAME;
      d   = q / SLOT;
      s   = (q % SLOT) / SC;
      lit = (s != 0) && (s <= int'(m_br)) && m_en[d] && !(m_blink[d] && m_phase);
      oh  = 4'b0001 << d;
      x.an   = lit ? ~oh : 4'hF;
      x.sseg = lit ? m_seg[d*8 +: 8] : 8'hFF;
      x.fs   = (q == 0);
      if (q == 0) begin
        m_seg   = segs_in;
        m_en    = digit_en;
        m_blink = blink_en;
        m_br    = brightness;
        m_phase = ((e_cnt / FRAME) % 4) >= 2;
      end
      e_cnt++;
    end
    sb.push_back(x);
    #1;
    y = sb.pop_front();
    chk("an", 32'(an), 32'(y.an));
    chk("sseg", 32'(sseg), 32'(y.sseg));
    chk("frame_start", 32'(frame_start), 32'(y.fs));
    chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
    if (an == 4'b1110) begin
      d0_lit++;
      last_d0 = sseg;
    end
    if (an == 4'b1101) d1_lit++;
    if (an != 4'hF) any_lit++;
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge is a frame load edge (bounded by one frame).
  task automatic align();
    for (int i = 0; i <= FRAME; i++) begin
      if (!reset && (e_cnt % FRAME) == 0) break;
      tick();
    end
  endtask

  int blink_exp[6] = '{30, 30, 0, 0, 30, 30};

  initial begin
    reset      = 1'b1;
    segs_in    = 32'hFFFF_FFFF;
    digit_en   = 4'h0;
    blink_en   = 4'h0;
    brightness = 4'd0;

    // Reset and idle: dark, frame_start on the second cycle after release, then every frame.
    run(3);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_sseg", 32'(sseg), 32'hFF);
    reset = 1'b0;
    tick();
    chk("first_fs", 32'(frame_start), 32'd1);
    clr();
    run(259);
    chk("idle_fs_count", fs_cnt, 2);
    chk("idle_lit", any_lit, 0);

    // Full brightness, all digits enabled.
    segs_in    = 32'hC0F9_A4B0;
    digit_en   = 4'hF;
    brightness = 4'd15;
    align();
    clr();
    run(FRAME);
    chk("br15_d0_lit", d0_lit, 30);
    chk("br15_any_lit", any_lit, 120);
    chk("br15_d0_seg", 32'(last_d0), 32'hB0);
    chk("br15_fs_count", fs_cnt, 1);

    // Brightness 4: subslots 1..4 only.
    brightness = 4'd4;
    clr();
    run(FRAME);
    chk("br4_d0_lit", d0_lit, 8);
    chk("br4_any_lit", any_lit, 32);

    // Brightness 0: permanently dark.
    brightness = 4'd0;
    clr();
    run(FRAME);
    chk("br0_any_lit", any_lit, 0);

    // Mid-frame pattern change is held off until the next frame load.
    brightness = 4'd15;
    clr();
    run(40);
    segs_in[7:0] = 8'h80;
    run(FRAME - 40);
    chk("mid_change_old_seg", 32'(last_d0), 32'hB0);
    clr();
    run(FRAME);
    chk("mid_change_new_seg", 32'(last_d0), 32'h80);
    chk("mid_change_d0_lit", d0_lit, 30);

    // Blink on digit 0 over frames 8..13.
    blink_en = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      clr();
      run(FRAME);
      chk("blink_d0_lit", d0_lit, blink_exp[f]);
      chk("blink_d1_lit", d1_lit, 30);
    end

    // Reset pulse while digit 2 is lit, then restart.
    run(76);
    chk("pre_reset_d2", 32'(an), 32'hB);
    reset = 1'b1;
    tick();
    chk("mid_reset_an", 32'(an), 32'hF);
    chk("mid_reset_sseg", 32'(sseg), 32'hFF);
    chk("mid_reset_fs", 32'(frame_start), 32'd0);
    reset = 1'b0;
    tick();
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_an", 32'(an), 32'hF);
    clr();
    run(300);
    chk("restart_fs_count", fs_cnt, 2);
    chk("restart_d0_lit", d0_lit, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
